// File: rtl/mem_stub_pkg.sv
// rtl/mem_stub_pkg.sv - shared types for the mem_stub multi-channel memory model
//
// Purpose : channel FSM state encoding, request kind, and the wait-counter
//           width/initialiser used by every mem_stub_channel instance.
// Ports   : none (package).
package mem_stub_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_WAIT    = 2'd1,
        CH_RESPOND = 2'd2,
        CH_RELEASE = 2'd3
    } ch_state_e;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // LATENCY is limited to 1..15, so four bits cover the wait counter.
    localparam int unsigned CNT_W = 4;

    // Counter value loaded when a request is accepted in IDLE.
    function automatic logic [CNT_W-1:0] wait_init(input int unsigned latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_stub_channel.sv
// rtl/mem_stub_channel.sv - one request channel: IDLE/WAIT/RESPOND/RELEASE FSM
//
// Purpose : accepts one read or write request in IDLE (read wins when both are
//           valid), waits so the ready pulse lands LATENCY cycles after the
//           request was sampled, pulses ready for one cycle, then holds until
//           the served valid drops before accepting again.
// Config  : MEM_STUB_OOB_CHECK_EN - when defined, oob_o flags a latched
//           address >= DEPTH; otherwise oob_o is 0 and the address wraps.
// Ports   : clk_i, reset_i                  clock, synchronous active-high reset
//           read_valid_i/read_address_i     read request
//           write_valid_i/write_address_i/write_data_i  write request
//           read_ready_o/write_ready_o      one-cycle response pulses
//           idx_o, oob_o, wdata_o           latched storage index, range flag, data
module mem_stub_channel
    import mem_stub_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  read_valid_i,
    input  logic [ADDR_WIDTH-1:0] read_address_i,
    input  logic                  write_valid_i,
    input  logic [ADDR_WIDTH-1:0] write_address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  read_ready_o,
    output logic                  write_ready_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  oob_o,
    output logic [DATA_WIDTH-1:0] wdata_o
);

    ch_state_e             state_q, state_d;
    req_kind_e             kind_q, kind_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  served_valid;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CH_IDLE;
            kind_q  <= REQ_READ;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign served_valid = (kind_q == REQ_READ) ? read_valid_i : write_valid_i;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            CH_IDLE: begin
                if (read_valid_i) begin
                    kind_d  = REQ_READ;
                    addr_d  = read_address_i;
                    cnt_d   = wait_init(LATENCY);
                    state_d = (LATENCY == 1) ? CH_RESPOND : CH_WAIT;
                end else if (write_valid_i) begin
                    kind_d  = REQ_WRITE;
                    addr_d  = write_address_i;
                    data_d  = write_data_i;
                    cnt_d   = wait_init(LATENCY);
                    state_d = (LATENCY == 1) ? CH_RESPOND : CH_WAIT;
                end
            end
            CH_WAIT: begin
                // Counter started at LATENCY-1; the step that reaches zero
                // moves to RESPOND, giving LATENCY-1 WAIT cycles in total.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = CH_RESPOND;
                end
            end
            CH_RESPOND: begin
                state_d = CH_RELEASE;
            end
            CH_RELEASE: begin
                if (!served_valid) begin
                    state_d = CH_IDLE;
                end
            end
            default: begin
                state_d = CH_IDLE;
            end
        endcase
    end

    // Ready is masked by reset so a transaction aborted in its RESPOND
    // cycle neither pulses nor commits.
    always_comb begin
        read_ready_o  = (state_q == CH_RESPOND) && (kind_q == REQ_READ)  && !reset_i;
        write_ready_o = (state_q == CH_RESPOND) && (kind_q == REQ_WRITE) && !reset_i;
    end

    assign idx_o   = addr_q[IDX_W-1:0];
    assign wdata_o = data_q;

`ifdef MEM_STUB_OOB_CHECK_EN
    assign oob_o = (64'(addr_q) >= 64'(DEPTH));
`else
    assign oob_o = 1'b0;
    if (ADDR_WIDTH > IDX_W) begin : g_wrap
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_q[ADDR_WIDTH-1:IDX_W];
    end
`endif

endmodule

// File: rtl/mem_stub.sv
// rtl/mem_stub.sv - multi-channel latency memory stub with shared storage
//
// Purpose : NUM_CHANNELS independent request channels over one storage array.
//           Reads return storage as of the start of the RESPOND cycle; writes
//           commit at the end of it. Same-cycle writes resolve as preload >
//           highest channel index > lower channel index. Storage is never
//           cleared by reset.
// Config  : MEM_STUB_OOB_CHECK_EN - when defined, accesses at address >= DEPTH
//           read 0, drop writes and set sticky err_oob_o; otherwise addresses
//           wrap modulo DEPTH and err_oob_o is 0.
// Ports   : clk_i, reset_i                                   clock, sync active-high reset
//           read_valid_i/read_address_i/read_ready_o/read_data_o   per-channel reads
//           write_valid_i/write_address_i/write_data_i/write_ready_o per-channel writes
//           preload_en_i/preload_addr_i/preload_data_i        host back-door write
//           err_oob_o                                         sticky out-of-range flag
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_stub
    import mem_stub_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = `DATA_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_WIDTH   = `DATA_WIDTH,
    parameter int DEPTH        = 256,
    parameter int LATENCY      = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CHANNELS-1:0] read_valid_i,
    input  logic [ADDR_WIDTH-1:0]   read_address_i [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] read_ready_o,
    output logic [DATA_WIDTH-1:0]   read_data_o [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] write_valid_i,
    input  logic [ADDR_WIDTH-1:0]   write_address_i [NUM_CHANNELS],
    input  logic [DATA_WIDTH-1:0]   write_data_i [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] write_ready_o,
    input  logic                    preload_en_i,
    input  logic [ADDR_WIDTH-1:0]   preload_addr_i,
    input  logic [DATA_WIDTH-1:0]   preload_data_i,
    output logic                    err_oob_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]      ch_idx   [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_oob;
    logic [IDX_W-1:0]      pl_idx;
    logic                  pl_ok;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        mem_stub_channel #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .LATENCY    (LATENCY),
            .IDX_W      (IDX_W)
        ) u_ch (
            .clk_i           (clk_i),
            .reset_i         (reset_i),
            .read_valid_i    (read_valid_i[g]),
            .read_address_i  (read_address_i[g]),
            .write_valid_i   (write_valid_i[g]),
            .write_address_i (write_address_i[g]),
            .write_data_i    (write_data_i[g]),
            .read_ready_o    (read_ready_o[g]),
            .write_ready_o   (write_ready_o[g]),
            .idx_o           (ch_idx[g]),
            .oob_o           (ch_oob[g]),
            .wdata_o         (ch_wdata[g])
        );
    end

    // Combinational read during RESPOND: sees storage before this cycle's
    // writes land, so a same-cycle read/write to one address returns old data.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            read_data_o[i] = '0;
            if (read_ready_o[i] && !ch_oob[i]) begin
                read_data_o[i] = mem_q[ch_idx[i]];
            end
        end
    end

    assign pl_idx = preload_addr_i[IDX_W-1:0];

`ifdef MEM_STUB_OOB_CHECK_EN
    assign pl_ok = (64'(preload_addr_i) < 64'(DEPTH));
`else
    assign pl_ok = 1'b1;
    if (ADDR_WIDTH > IDX_W) begin : g_pl_wrap
        logic unused_pl_hi;
        assign unused_pl_hi = ^preload_addr_i[ADDR_WIDTH-1:IDX_W];
    end
`endif

    // Later assignments win, so ascending channel order followed by the
    // preload port yields preload > highest index > lower index.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (write_ready_o[i] && !ch_oob[i]) begin
                mem_q[ch_idx[i]] <= ch_wdata[i];
            end
        end
        if (preload_en_i && pl_ok) begin
            mem_q[pl_idx] <= preload_data_i;
        end
    end

`ifdef MEM_STUB_OOB_CHECK_EN
    logic err_oob_q;
    logic err_oob_d;

    always_comb begin
        err_oob_d = err_oob_q | (|((read_ready_o | write_ready_o) & ch_oob));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= err_oob_d;
        end
    end

    assign err_oob_o = err_oob_q;
`else
    assign err_oob_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stub.sv
// tb/tb_mem_stub.sv - scoreboard bench for mem_stub (8 channels, LATENCY 2)
module tb_mem_stub;

    localparam int NC  = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] read_valid, read_ready, write_valid, write_ready;
    logic [AW-1:0] read_address [NC];
    logic [AW-1:0] write_address [NC];
    logic [DW-1:0] read_data [NC];
    logic [DW-1:0] write_data [NC];
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [DW-1:0] preload_data;
    logic          err_oob;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stub #(
        .NUM_CHANNELS (NC),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (256),
        .LATENCY      (LAT)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .read_valid_i    (read_valid),
        .read_address_i  (read_address),
        .read_ready_o    (read_ready),
        .read_data_o     (read_data),
        .write_valid_i   (write_valid),
        .write_address_i (write_address),
        .write_data_i    (write_data),
        .write_ready_o   (write_ready),
        .preload_en_i    (preload_en),
        .preload_addr_i  (preload_addr),
        .preload_data_i  (preload_data),
        .err_oob_o       (err_oob)
    );

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [NC-1:0] hold_rd = '0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic handle(input int ch, input bit wr, input logic [31:0] data);
        int idx;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].ch == ch && sb[k].wr == wr) idx = k;
        end
        if (idx < 0) begin
            check($sformatf("unexpected_%s_ready_ch%0d", wr ? "wr" : "rd", ch), 32'd1, 32'd0);
        end else begin
            if (!wr) check($sformatf("rd_data_ch%0d", ch), data, sb[idx].data);
            check($sformatf("%s_latency_ch%0d", wr ? "wr" : "rd", ch), cyc, sb[idx].due);
            sb.delete(idx);
        end
    endtask

    // Advance to the next falling edge, score every ready seen there and
    // drop the served valid (unless the channel is deliberately holding it).
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (read_ready[i]) begin
                handle(i, 1'b0, read_data[i]);
                if (!hold_rd[i]) read_valid[i] = 1'b0;
            end
            if (write_ready[i]) begin
                handle(i, 1'b1, '0);
                write_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic issue_rd(input int ch, input logic [31:0] addr, input logic [31:0] exp);
        read_address[ch] = addr;
        read_valid[ch]   = 1'b1;
        sb.push_back('{ch: ch, wr: 1'b0, data: exp, due: cyc + LAT});
    endtask

    task automatic issue_wr(input int ch, input logic [31:0] addr, input logic [31:0] data);
        write_address[ch] = addr;
        write_data[ch]    = data;
        write_valid[ch]   = 1'b1;
        sb.push_back('{ch: ch, wr: 1'b1, data: data, due: cyc + LAT});
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() > 0 && b < 50) begin
            step();
            b++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
        step();
        step();
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        preload_en   = 1'b1;
        preload_addr = addr;
        preload_data = data;
        step();
        preload_en   = 1'b0;
    endtask

    initial begin
        int seen;
        reset        = 1'b1;
        read_valid   = '0;
        write_valid  = '0;
        preload_en   = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        for (int i = 0; i < NC; i++) begin
            read_address[i]  = '0;
            write_address[i] = '0;
            write_data[i]    = '0;
        end
        repeat (3) step();
        check("reset_read_ready", 32'(read_ready), 32'd0);
        check("reset_write_ready", 32'(write_ready), 32'd0);
        check("reset_read_data0", read_data[0], 32'd0);
        check("reset_err_oob", 32'(err_oob), 32'd0);
        reset = 1'b0;
        step();

        preload(32'd5, 32'hDEAD_BEEF);
        for (int i = 0; i < NC; i++) preload(32'(10 + i), 32'hA000_0000 + 32'(i));
        preload(32'd3, 32'h0000_0033);
        preload(32'd7, 32'h0000_1234);
        preload(32'd20, 32'h0000_2020);
        preload(32'd44, 32'h4444_4444);

        // Single read, exact latency.
        issue_rd(0, 32'd5, 32'hDEAD_BEEF);
        drain();

        // All channels in the same cycle.
        for (int i = 0; i < NC; i++) issue_rd(i, 32'(10 + i), 32'hA000_0000 + 32'(i));
        drain();

        // Colliding writes: highest channel wins.
        issue_wr(1, 32'd3, 32'h11);
        issue_wr(6, 32'd3, 32'h66);
        drain();
        issue_rd(4, 32'd3, 32'h66);
        drain();

        // Same-cycle read and write of one address returns the old value.
        issue_rd(2, 32'd20, 32'h0000_2020);
        issue_wr(0, 32'd20, 32'h5555_0000);
        drain();
        issue_rd(2, 32'd20, 32'h5555_0000);
        drain();

        // Held valid must not re-trigger until it drops for a cycle.
        hold_rd[2] = 1'b1;
        issue_rd(2, 32'd10, 32'hA000_0000);
        drain();
        seen = 0;
        repeat (6) begin
            step();
            if (read_ready[2]) seen++;
        end
        check("hold_no_second_ready", seen, 0);
        read_valid[2] = 1'b0;
        step();
        hold_rd[2] = 1'b0;
        issue_rd(2, 32'd11, 32'hA000_0001);
        drain();

        // Reset aborts a latched write; a read held across reset is served.
        write_address[0] = 32'd7;
        write_data[0]    = 32'h77;
        write_valid[0]   = 1'b1;
        step();
        reset            = 1'b1;
        write_valid[0]   = 1'b0;
        read_address[3]  = 32'd5;
        read_valid[3]    = 1'b1;
        step();
        step();
        reset = 1'b0;
        sb.push_back('{ch: 3, wr: 1'b0, data: 32'hDEAD_BEEF, due: cyc + LAT});
        drain();
        issue_rd(0, 32'd7, 32'h0000_1234);
        drain();

        // Out-of-range address.
`ifdef MEM_STUB_OOB_CHECK_EN
        issue_rd(5, 32'd300, 32'h0);
        drain();
        check("err_oob_set", 32'(err_oob), 32'd1);
        step();
        check("err_oob_sticky", 32'(err_oob), 32'd1);
`else
        issue_rd(5, 32'd300, 32'h4444_4444);
        drain();
        check("err_oob_tied", 32'(err_oob), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
